// File: rtl/i2c_eeprom_sched_if.sv
// Command/response channel between the EEPROM transaction scheduler and the
// byte-level I2C master engine. One command is outstanding at a time.
interface i2c_eeprom_sched_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       cmd_nack;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;

    modport master (
        output cmd_valid, cmd_op, cmd_wdata, cmd_nack,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_wdata, cmd_nack,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_nack
    );
endinterface

// File: rtl/i2c_eeprom_sched.sv
// Round-robin scheduler turning two clients' byte requests into 24Cxx random
// write/read command sequences for a shared I2C byte engine.
module i2c_eeprom_sched #(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned WR_WAIT_CYC = 250000
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [1:0]         req_rd,
    input  logic [15:0]        req_addr,
    input  logic [15:0]        req_wdata,
    output logic [1:0]         grant,
    output logic [1:0]         done,
    output logic [7:0]         rdata,
    output logic               err,
    output logic               busy,
    i2c_eeprom_sched_if.master eng
);

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARB      = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_RSP = 3'd3,
        S_WR_WAIT  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] data;
        logic       nack;
    } cmd_t;

    // Step index -> command; anything past the last step is STOP.
    function automatic cmd_t cmd_decode(input logic rd, input logic [2:0] step,
                                        input logic [7:0] addr, input logic [7:0] wdata);
        cmd_t c;
        c.op   = OP_STOP;
        c.data = 8'h00;
        c.nack = 1'b0;
        if (rd) begin
            case (step)
                3'd0:    c.op = OP_START;
                3'd1:    begin c.op = OP_WRITE; c.data = {DEV_ADDR, 1'b0}; end
                3'd2:    begin c.op = OP_WRITE; c.data = addr; end
                3'd3:    c.op = OP_START;
                3'd4:    begin c.op = OP_WRITE; c.data = {DEV_ADDR, 1'b1}; end
                3'd5:    begin c.op = OP_READ;  c.nack = 1'b1; end
                default: c.op = OP_STOP;
            endcase
        end else begin
            case (step)
                3'd0:    c.op = OP_START;
                3'd1:    begin c.op = OP_WRITE; c.data = {DEV_ADDR, 1'b0}; end
                3'd2:    begin c.op = OP_WRITE; c.data = addr; end
                3'd3:    begin c.op = OP_WRITE; c.data = wdata; end
                default: c.op = OP_STOP;
            endcase
        end
        return c;
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  step_r, step_s;
    logic        owner_r, owner_s;
    logic        rd_r, rd_s;
    logic [7:0]  addr_r, addr_s;
    logic [7:0]  wdata_r, wdata_s;
    logic        abort_r, abort_s;
    logic        ptr_r, ptr_s;
    logic [31:0] cnt_r, cnt_s;
    logic [7:0]  rcap_r, rcap_s;
    logic [1:0]  grant_r, grant_s;
    logic [1:0]  done_r, done_s;
    logic [7:0]  rdata_r, rdata_s;
    logic        err_r, err_s;
    logic        busy_r, busy_s;
    logic        cmd_valid_r, cmd_valid_s;
    cmd_t        cmd_r, cmd_s;
    logic        win_s;
    logic        hs_s;

    // On a tie the client that was not served last wins.
    assign win_s = (req == 2'b11) ? ~ptr_r : req[1];
    assign hs_s  = cmd_valid_r & eng.cmd_ready;

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        state_s     = state_r;
        step_s      = step_r;
        owner_s     = owner_r;
        rd_s        = rd_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        abort_s     = abort_r;
        ptr_s       = ptr_r;
        cnt_s       = cnt_r;
        rcap_s      = rcap_r;
        grant_s     = grant_r;
        busy_s      = busy_r;
        done_s      = 2'b00;
        err_s       = 1'b0;
        rdata_s     = rdata_r;
        cmd_valid_s = cmd_valid_r;
        cmd_s       = cmd_r;
        case (state_r)
            S_IDLE: begin
                if (|req) begin
                    owner_s = win_s;
                    rd_s    = req_rd[win_s];
                    addr_s  = win_s ? req_addr[15:8]  : req_addr[7:0];
                    wdata_s = win_s ? req_wdata[15:8] : req_wdata[7:0];
                    grant_s = win_s ? 2'b10 : 2'b01;
                    busy_s  = 1'b1;
                    step_s  = 3'd0;
                    abort_s = 1'b0;
                    state_s = S_ARB;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ARB: begin
                cmd_s       = cmd_decode(rd_r, step_r, addr_r, wdata_r);
                cmd_valid_s = 1'b1;
                state_s     = S_ISSUE;
            end
            S_ISSUE: begin
                if (hs_s) begin
                    cmd_valid_s = 1'b0;
                    state_s     = S_WAIT_RSP;
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_WAIT_RSP: begin
                if (eng.rsp_valid) begin
                    if (cmd_r.op == OP_STOP) begin
                        if (!abort_r && !rd_r) begin
                            cnt_s   = 32'd0;
                            state_s = S_WR_WAIT;
                        end else begin
                            done_s  = grant_r;
                            err_s   = abort_r;
                            rdata_s = abort_r ? rdata_r : rcap_r;
                            state_s = S_DONE;
                        end
                    end else begin
                        if (cmd_r.op == OP_READ) begin
                            rcap_s = eng.rsp_rdata;
                        end else begin
                            rcap_s = rcap_r;
                        end
                        // A NACK only aborts on bytes the master sent.
                        if (cmd_r.op == OP_WRITE && eng.rsp_nack) begin
                            abort_s = 1'b1;
                            step_s  = rd_r ? 3'd6 : 3'd4;
                        end else begin
                            step_s = step_r + 3'd1;
                        end
                        cmd_s       = cmd_decode(rd_r, step_s, addr_r, wdata_r);
                        cmd_valid_s = 1'b1;
                        state_s     = S_ISSUE;
                    end
                end else begin
                    state_s = S_WAIT_RSP;
                end
            end
            S_WR_WAIT: begin
                if (cnt_r == WR_WAIT_CYC - 32'd1) begin
                    done_s  = grant_r;
                    err_s   = abort_r;
                    state_s = S_DONE;
                end else begin
                    cnt_s = cnt_r + 32'd1;
                end
            end
            S_DONE: begin
                ptr_s   = owner_r;
                grant_s = 2'b00;
                busy_s  = 1'b0;
                abort_s = 1'b0;
                state_s = S_IDLE;
            end
            default: begin
                state_s     = S_IDLE;
                grant_s     = 2'b00;
                busy_s      = 1'b0;
                cmd_valid_s = 1'b0;
            end
        endcase
    end

    // State, context and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            step_r      <= 3'd0;
            owner_r     <= 1'b0;
            rd_r        <= 1'b0;
            addr_r      <= 8'h00;
            wdata_r     <= 8'h00;
            abort_r     <= 1'b0;
            ptr_r       <= 1'b1;
            cnt_r       <= 32'd0;
            rcap_r      <= 8'h00;
            grant_r     <= 2'b00;
            done_r      <= 2'b00;
            rdata_r     <= 8'h00;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            cmd_valid_r <= 1'b0;
            cmd_r       <= '0;
        end else begin
            state_r     <= state_s;
            step_r      <= step_s;
            owner_r     <= owner_s;
            rd_r        <= rd_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            abort_r     <= abort_s;
            ptr_r       <= ptr_s;
            cnt_r       <= cnt_s;
            rcap_r      <= rcap_s;
            grant_r     <= grant_s;
            done_r      <= done_s;
            rdata_r     <= rdata_s;
            err_r       <= err_s;
            busy_r      <= busy_s;
            cmd_valid_r <= cmd_valid_s;
            cmd_r       <= cmd_s;
        end
    end

    assign grant         = grant_r;
    assign done          = done_r;
    assign rdata         = rdata_r;
    assign err           = err_r;
    assign busy          = busy_r;
    assign eng.cmd_valid = cmd_valid_r;
    assign eng.cmd_op    = cmd_r.op;
    assign eng.cmd_wdata = cmd_r.data;
    assign eng.cmd_nack  = cmd_r.nack;

endmodule

// File: tb/tb_i2c_eeprom_sched.sv
// Directed bench for i2c_eeprom_sched with a behavioural byte engine that
// logs every accepted command and answers one cycle after the handshake.
module tb_i2c_eeprom_sched;
    localparam int unsigned WAITC = 8;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [1:0]  req, req_rd, grant, done;
    logic [15:0] req_addr, req_wdata;
    logic [7:0]  rdata;
    logic        err, busy;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    i2c_eeprom_sched_if eng();

    i2c_eeprom_sched #(.DEV_ADDR(7'h50), .WR_WAIT_CYC(WAITC)) dut (
        .sys_clk(sys_clk), .rst(rst), .req(req), .req_rd(req_rd),
        .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
        .rdata(rdata), .err(err), .busy(busy), .eng(eng.master)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Engine model state
    int         stall_cfg = 0;
    int         nack_idx  = -1;
    logic [7:0] rd_val    = 8'h00;
    logic [1:0] log_op[$];
    logic [7:0] log_data[$];
    logic       log_nack[$];
    logic       pending;
    logic [1:0] pend_op;
    int         pend_idx;
    int         st;
    logic [1:0] hold_op;
    logic [7:0] hold_data;
    logic       hold_nack;

    function automatic logic [25:0] outs();
        return {grant, done, rdata, err, busy, eng.cmd_valid, eng.cmd_op, eng.cmd_wdata, eng.cmd_nack};
    endfunction

    // Behavioural byte engine, decides its inputs on the falling edge.
    initial begin
        eng.cmd_ready = 1'b1;
        eng.rsp_valid = 1'b0;
        eng.rsp_rdata = 8'h00;
        eng.rsp_nack  = 1'b0;
        pending = 1'b0;
        st = 0;
        forever begin
            @(negedge sys_clk);
            eng.rsp_valid = 1'b0;
            eng.rsp_nack  = 1'b0;
            eng.rsp_rdata = 8'h00;
            if (rst) begin
                pending = 1'b0;
                st = 0;
                eng.cmd_ready = (stall_cfg == 0);
            end else begin
                if (pending) begin
                    eng.rsp_valid = 1'b1;
                    if (pend_op == 2'd2) eng.rsp_rdata = rd_val;
                    if (pend_op == 2'd1 && pend_idx == nack_idx) eng.rsp_nack = 1'b1;
                    pending = 1'b0;
                end
                if (eng.cmd_valid) begin
                    if (st > 0) begin
                        checks++;
                        if (eng.cmd_op !== hold_op || eng.cmd_wdata !== hold_data || eng.cmd_nack !== hold_nack) begin
                            errors++;
                            $display("FAIL cmd_stable: got op=%0d data=%h nack=%b, required op=%0d data=%h nack=%b",
                                     eng.cmd_op, eng.cmd_wdata, eng.cmd_nack, hold_op, hold_data, hold_nack);
                        end
                    end else begin
                        hold_op = eng.cmd_op;
                        hold_data = eng.cmd_wdata;
                        hold_nack = eng.cmd_nack;
                    end
                    if (st < stall_cfg) begin
                        eng.cmd_ready = 1'b0;
                        st++;
                    end else begin
                        eng.cmd_ready = 1'b1;
                        st = 0;
                        log_op.push_back(eng.cmd_op);
                        log_data.push_back(eng.cmd_wdata);
                        log_nack.push_back(eng.cmd_nack);
                        pending = 1'b1;
                        pend_op = eng.cmd_op;
                        pend_idx = log_op.size() - 1;
                    end
                end else begin
                    eng.cmd_ready = (stall_cfg == 0);
                    st = 0;
                end
            end
        end
    end

    // err must never be raised outside a done pulse.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!rst) begin
                checks++;
                if (err === 1'b1 && done === 2'b00) begin
                    errors++;
                    $display("FAIL err_without_done: got err=1 done=%b, required err=0", done);
                end
            end
        end
    end

    task automatic clear_log();
        log_op.delete();
        log_data.delete();
        log_nack.delete();
    endtask

    task automatic wait_done(output int at);
        int n;
        n = 0;
        at = -1;
        while (done === 2'b00 && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        if (done === 2'b00) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done after %0d cycles, required a done pulse", n);
        end else begin
            at = cyc;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b00; req_rd = 2'b00; req_addr = 16'h0000; req_wdata = 16'h0000;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (outs() !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", outs());
        end
        rst = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (outs() !== 26'd0) begin
            errors++;
            $display("FAIL idle_outputs: got %h, required 0", outs());
        end
    endtask

    task automatic test_single_write();
        int t0, at;
        logic [1:0] eop[5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
        logic [7:0] edat[5] = '{8'h00, 8'hA0, 8'h12, 8'hA5, 8'h00};
        clear_log();
        req_rd = 2'b10; req_addr = 16'hEE12; req_wdata = 16'hDDA5; req = 2'b01;
        t0 = cyc;
        @(negedge sys_clk);
        checks++;
        if (grant !== 2'b01 || busy !== 1'b1 || eng.cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_grant: got grant=%b busy=%b valid=%b, required 01 1 0", grant, busy, eng.cmd_valid);
        end
        @(negedge sys_clk);
        checks++;
        if (eng.cmd_valid !== 1'b1 || eng.cmd_op !== 2'd0) begin
            errors++;
            $display("FAIL wr_first_cmd: got valid=%b op=%0d, required 1 0", eng.cmd_valid, eng.cmd_op);
        end
        wait_done(at);
        req = 2'b00;
        checks++;
        if (at - t0 != 20 || done !== 2'b01 || err !== 1'b0 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL wr_done: got lat=%0d done=%b err=%b rdata=%h, required 20 01 0 00", at - t0, done, err, rdata);
        end
        checks++;
        if (log_op.size() != 5) begin
            errors++;
            $display("FAIL wr_cmd_count: got %0d, required 5", log_op.size());
        end
        for (int i = 0; i < 5 && i < log_op.size(); i++) begin
            checks++;
            if (log_op[i] !== eop[i] || (eop[i] == 2'd1 && log_data[i] !== edat[i])) begin
                errors++;
                $display("FAIL wr_cmd%0d: got op=%0d data=%h, required op=%0d data=%h", i, log_op[i], log_data[i], eop[i], edat[i]);
            end
        end
        @(negedge sys_clk);
        checks++;
        if (done !== 2'b00 || busy !== 1'b0 || grant !== 2'b00) begin
            errors++;
            $display("FAIL wr_after_done: got done=%b busy=%b grant=%b, required 00 0 00", done, busy, grant);
        end
    endtask

    task automatic test_single_read();
        int t0, at;
        logic [1:0] eop[7] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [7:0] edat[7] = '{8'h00, 8'hA0, 8'h34, 8'h00, 8'hA1, 8'h00, 8'h00};
        clear_log();
        rd_val = 8'h5C;
        req_rd = 2'b10; req_addr = 16'h3477; req_wdata = 16'h0000; req = 2'b10;
        t0 = cyc;
        @(negedge sys_clk);
        checks++;
        if (grant !== 2'b10 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL rd_grant: got grant=%b rdata=%h, required 10 00", grant, rdata);
        end
        wait_done(at);
        req = 2'b00;
        checks++;
        if (at - t0 != 16 || done !== 2'b10 || err !== 1'b0 || rdata !== 8'h5C) begin
            errors++;
            $display("FAIL rd_done: got lat=%0d done=%b err=%b rdata=%h, required 16 10 0 5c", at - t0, done, err, rdata);
        end
        checks++;
        if (log_op.size() != 7) begin
            errors++;
            $display("FAIL rd_cmd_count: got %0d, required 7", log_op.size());
        end
        for (int i = 0; i < 7 && i < log_op.size(); i++) begin
            checks++;
            if (log_op[i] !== eop[i] || (eop[i] == 2'd1 && log_data[i] !== edat[i]) ||
                (eop[i] == 2'd2 && log_nack[i] !== 1'b1)) begin
                errors++;
                $display("FAIL rd_cmd%0d: got op=%0d data=%h nack=%b, required op=%0d data=%h",
                         i, log_op[i], log_data[i], log_nack[i], eop[i], edat[i]);
            end
        end
        @(negedge sys_clk);
    endtask

    task automatic test_backpressure();
        int t0, at;
        logic [1:0] eop[5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
        logic [7:0] edat[5] = '{8'h00, 8'hA0, 8'h77, 8'h3C, 8'h00};
        clear_log();
        stall_cfg = 5;
        @(negedge sys_clk);
        req_rd = 2'b01; req_addr = 16'h7711; req_wdata = 16'h3C22; req = 2'b10;
        t0 = cyc;
        wait_done(at);
        req = 2'b00;
        checks++;
        if (at - t0 != 45 || done !== 2'b10 || err !== 1'b0 || rdata !== 8'h5C) begin
            errors++;
            $display("FAIL bp_done: got lat=%0d done=%b err=%b rdata=%h, required 45 10 0 5c", at - t0, done, err, rdata);
        end
        checks++;
        if (log_op.size() != 5) begin
            errors++;
            $display("FAIL bp_cmd_count: got %0d, required 5", log_op.size());
        end
        for (int i = 0; i < 5 && i < log_op.size(); i++) begin
            checks++;
            if (log_op[i] !== eop[i] || (eop[i] == 2'd1 && log_data[i] !== edat[i])) begin
                errors++;
                $display("FAIL bp_cmd%0d: got op=%0d data=%h, required op=%0d data=%h", i, log_op[i], log_data[i], eop[i], edat[i]);
            end
        end
        stall_cfg = 0;
        @(negedge sys_clk);
    endtask

    task automatic test_nack_abort();
        int t0, at;
        logic [1:0] eop[3] = '{2'd0, 2'd1, 2'd3};
        clear_log();
        nack_idx = 1;
        req_rd = 2'b00; req_addr = 16'h0055; req_wdata = 16'h0099; req = 2'b01;
        t0 = cyc;
        wait_done(at);
        req = 2'b00;
        checks++;
        if (at - t0 != 8 || done !== 2'b01 || err !== 1'b1 || rdata !== 8'h5C) begin
            errors++;
            $display("FAIL nack_done: got lat=%0d done=%b err=%b rdata=%h, required 8 01 1 5c", at - t0, done, err, rdata);
        end
        checks++;
        if (log_op.size() != 3) begin
            errors++;
            $display("FAIL nack_cmd_count: got %0d, required 3", log_op.size());
        end
        for (int i = 0; i < 3 && i < log_op.size(); i++) begin
            checks++;
            if (log_op[i] !== eop[i]) begin
                errors++;
                $display("FAIL nack_cmd%0d: got op=%0d, required op=%0d", i, log_op[i], eop[i]);
            end
        end
        nack_idx = -1;
        @(negedge sys_clk);
    endtask

    task automatic test_back_to_back();
        int at, prev;
        logic [1:0] exp;
        rst = 1'b1;
        req = 2'b11; req_rd = 2'b11; req_addr = 16'h0201; rd_val = 8'h42;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge sys_clk);
            wait_done(at);
            if (k == 3) req = 2'b00;
            checks++;
            if (done !== exp || grant !== exp || rdata !== 8'h42) begin
                errors++;
                $display("FAIL rr_txn%0d: got done=%b grant=%b rdata=%h, required done=grant=%b rdata=42", k, done, grant, rdata, exp);
            end
            if (k > 0) begin
                checks++;
                if (at - prev != 17) begin
                    errors++;
                    $display("FAIL rr_spacing%0d: got %0d, required 17", k, at - prev);
                end
            end
            prev = at;
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: got grant=%b busy=%b, required 00 0", grant, busy);
        end
    endtask

    task automatic test_reset_mid_read();
        int n, at;
        clear_log();
        req_rd = 2'b01; req_addr = 16'h0020; req = 2'b01;
        n = 0;
        while (log_op.size() < 3 && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        checks++;
        if (log_op.size() < 3) begin
            errors++;
            $display("FAIL mid_cmds: got %0d commands, required 3", log_op.size());
        end
        @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (outs() !== 26'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h, required 0", outs());
        end
        clear_log();
        rst = 1'b0;
        req = 2'b11; req_rd = 2'b11; req_addr = 16'h0B0A; rd_val = 8'h66;
        @(negedge sys_clk);
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL mid_regrant: got %b, required 01", grant);
        end
        wait_done(at);
        req = 2'b00;
        checks++;
        if (done !== 2'b01 || err !== 1'b0 || rdata !== 8'h66) begin
            errors++;
            $display("FAIL mid_done: got done=%b err=%b rdata=%h, required 01 0 66", done, err, rdata);
        end
        checks++;
        if (log_op.size() != 7 || log_data[2] !== 8'h0A) begin
            errors++;
            $display("FAIL mid_cmds_after: got count=%0d, required 7 with address 0a", log_op.size());
        end
        @(negedge sys_clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_backpressure();
        test_nack_abort();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
